// File: rtl/fir_feeder.sv
// fir_feeder: drives the FIR filter's sample/coefficient handshake.
// Samples are buffered in a small FIFO, coefficients live in a local
// register file, and each accepted sample yields one result word.
module fir_feeder #(
    parameter int FIFO_DEPTH = 4,
    parameter int NUM_COEFF  = 4,
    parameter int TIMEOUT    = 16,
    parameter int DATA_W     = 16,
    parameter int COEF_W     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     coeff_wr,
    input  logic [1:0]               coeff_waddr,
    input  logic signed [COEF_W-1:0] coeff_wdata,
    input  logic                     reload,
    input  logic                     sample_valid,
    input  logic signed [DATA_W-1:0] sample_in,
    output logic                     sample_ready,
    input  logic                     modwait,
    input  logic signed [DATA_W-1:0] fir_out,
    input  logic                     err,
    output logic signed [DATA_W-1:0] sample_data,
    output logic signed [COEF_W-1:0] fir_coefficient,
    output logic                     data_ready,
    output logic                     load_coeff,
    output logic                     result_valid,
    output logic signed [DATA_W-1:0] result_data,
    output logic                     result_err,
    output logic                     coeff_done,
    output logic                     timeout_err
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int IDX_W = (NUM_COEFF > 1) ? $clog2(NUM_COEFF) : 1;
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_COEF_DRIVE = 3'd1;
    localparam logic [2:0] S_COEF_WAIT  = 3'd2;
    localparam logic [2:0] S_SAMP_DRIVE = 3'd3;
    localparam logic [2:0] S_SAMP_WAIT  = 3'd4;

    logic signed [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]         wr_ptr;
    logic [PTR_W-1:0]         rd_ptr;
    logic [CNT_W-1:0]         count;
    logic [CNT_W-1:0]         count_nxt;
    logic                     push;
    logic                     pop;

    logic signed [COEF_W-1:0] coeff [NUM_COEFF];
    logic [2:0]               state;
    logic [IDX_W-1:0]         idx;
    logic [IDX_W-1:0]         idx_nxt;
    logic [TMR_W-1:0]         timer;
    logic                     tmo_hit;
    logic                     reload_pend;

    // FIFO handshake and occupancy bookkeeping
    always_comb begin
        push      = sample_valid && sample_ready;
        pop       = (state == S_SAMP_DRIVE) && modwait;
        count_nxt = count + CNT_W'(push) - CNT_W'(pop);
        idx_nxt   = idx + 1'b1;
        tmo_hit   = (timer == TMR_W'(TIMEOUT - 1));
    end

    // FIFO pointers, count and the registered not-full flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            sample_ready <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count        <= count_nxt;
            sample_ready <= (count_nxt != CNT_W'(FIFO_DEPTH));
        end
    end

    // FIFO storage; contents are meaningless while count is zero
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= sample_in;
    end

    // Coefficient register file, writable at any time
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_COEFF; i++) coeff[i] <= '0;
        end else if (coeff_wr && (int'(coeff_waddr) < NUM_COEFF)) begin
            coeff[IDX_W'(coeff_waddr)] <= coeff_wdata;
        end
    end

    // Handshake sequencer with per-state timeout watchdog
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= S_IDLE;
            idx             <= '0;
            timer           <= '0;
            reload_pend     <= 1'b0;
            sample_data     <= '0;
            fir_coefficient <= '0;
            data_ready      <= 1'b0;
            load_coeff      <= 1'b0;
            result_valid    <= 1'b0;
            result_data     <= '0;
            result_err      <= 1'b0;
            coeff_done      <= 1'b0;
            timeout_err     <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            coeff_done   <= 1'b0;
            // A reload seen while a sequence runs just keeps the flag set,
            // so back-to-back requests collapse into a single extra pass.
            if (reload) reload_pend <= 1'b1;

            case (state)
                S_IDLE: begin
                    timer <= '0;
                    idx   <= '0;
                    if (!modwait) begin
                        if (reload_pend) begin
                            reload_pend     <= 1'b0;
                            fir_coefficient <= coeff[0];
                            load_coeff      <= 1'b1;
                            state           <= S_COEF_DRIVE;
                        end else if (count != '0) begin
                            sample_data <= fifo_mem[rd_ptr];
                            data_ready  <= 1'b1;
                            state       <= S_SAMP_DRIVE;
                        end
                    end
                end

                S_COEF_DRIVE: begin
                    if (modwait) begin
                        load_coeff <= 1'b0;
                        timer      <= '0;
                        state      <= S_COEF_WAIT;
                    end else if (tmo_hit) begin
                        timeout_err <= 1'b1;
                        load_coeff  <= 1'b0;
                        timer       <= '0;
                        state       <= S_IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                S_COEF_WAIT: begin
                    if (!modwait) begin
                        timer <= '0;
                        if (idx == IDX_W'(NUM_COEFF - 1)) begin
                            coeff_done <= 1'b1;
                            state      <= S_IDLE;
                        end else begin
                            // Slot value is captured here, so a write landing
                            // after this point only shows on the next reload.
                            idx             <= idx_nxt;
                            fir_coefficient <= coeff[idx_nxt];
                            load_coeff      <= 1'b1;
                            state           <= S_COEF_DRIVE;
                        end
                    end else if (tmo_hit) begin
                        timeout_err <= 1'b1;
                        timer       <= '0;
                        state       <= S_IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                S_SAMP_DRIVE: begin
                    // The FIFO pop happens alongside this transition; an abort
                    // leaves the head in place so it is reissued later.
                    if (modwait) begin
                        data_ready <= 1'b0;
                        timer      <= '0;
                        state      <= S_SAMP_WAIT;
                    end else if (tmo_hit) begin
                        timeout_err <= 1'b1;
                        data_ready  <= 1'b0;
                        timer       <= '0;
                        state       <= S_IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                S_SAMP_WAIT: begin
                    if (!modwait) begin
                        result_data  <= fir_out;
                        result_err   <= err;
                        result_valid <= 1'b1;
                        timer        <= '0;
                        state        <= S_IDLE;
                    end else if (tmo_hit) begin
                        timeout_err <= 1'b1;
                        timer       <= '0;
                        state       <= S_IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                default: begin
                    data_ready <= 1'b0;
                    load_coeff <= 1'b0;
                    timer      <= '0;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/fir_feeder.md
Name: fir_feeder

Overview:
- Initiator for the FIR filter's sample/coefficient handshake. Drives data_ready, load_coeff, sample_data and fir_coefficient into the filter.
- Observes the filter's modwait, fir_out and err, and returns one result word per sample.
- Buffers incoming samples in a small FIFO and holds the coefficient set in a local register file.
- Sits between the test/host logic and the fir_filter top level.

Parameters:
- FIFO_DEPTH, 4: sample FIFO entries; power of two, at least 2.
- NUM_COEFF, 4: coefficients loaded per reload request.
- TIMEOUT, 16: maximum cycles spent waiting for any modwait edge before aborting.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- coeff_wr  in  1  writes coeff_wdata into coefficient slot coeff_waddr.
- coeff_waddr  in  2  coefficient slot index.
- coeff_wdata  in  16  coefficient value.
- reload  in  1  one-cycle pulse; requests that all NUM_COEFF coefficients be sent to the filter.
- sample_valid  in  1  sample push request.
- sample_in  in  16  sample value.
- sample_ready  out  1  FIFO not full.
- modwait  in  1  busy flag from the filter.
- fir_out  in  16  filter result.
- err  in  1  filter error flag.
- sample_data  out  16  sample presented to the filter.
- fir_coefficient  out  16  coefficient presented to the filter.
- data_ready  out  1  sample strobe to the filter.
- load_coeff  out  1  coefficient strobe to the filter.
- result_valid  out  1  one-cycle pulse; result_data and result_err are valid.
- result_data  out  16  captured fir_out.
- result_err  out  1  captured err.
- coeff_done  out  1  one-cycle pulse after the last coefficient is accepted.
- timeout_err  out  1  sticky; cleared only by rst.

Behaviour:
- Reset (async, rst=1):
  - All outputs 0; FIFO empty (sample_ready=1 once rst releases).
  - Coefficient slots 0; state IDLE; pending reload cleared; indices and timer 0.
- FIFO:
  - Push when sample_valid && sample_ready.
  - Pop happens only in SAMP_DRIVE on modwait rising.
  - Push and pop in the same cycle when full: the push is refused because sample_ready=0.
  - Pointers wrap modulo FIFO_DEPTH; occupancy is tracked with a count register.
- Coefficient writes:
  - Accepted in any state.
  - A write to a slot that is currently being transmitted takes effect on the next reload only: fir_coefficient is registered at entry to COEF_DRIVE.
- reload:
  - Latched into a pending flag.
  - A reload arriving while a reload sequence is active is merged into the pending flag, not queued twice.
- FSM, all outputs registered:
  - IDLE: requires modwait=0. Pending reload has priority: clear the flag, idx=0, go to COEF_DRIVE. Otherwise, if the FIFO is non-empty, go to SAMP_DRIVE.
  - COEF_DRIVE: load_coeff=1, fir_coefficient=coeff[idx]. On modwait=1: load_coeff←0, go to COEF_WAIT.
  - COEF_WAIT: on modwait=0, if idx==NUM_COEFF-1, pulse coeff_done and go to IDLE; else idx+1 and go to COEF_DRIVE.
  - SAMP_DRIVE: data_ready=1, sample_data=FIFO head (registered at entry). On modwait=1: data_ready←0, pop, go to SAMP_WAIT.
  - SAMP_WAIT: on modwait=0, capture fir_out→result_data and err→result_err, result_valid=1 for exactly one cycle, go to IDLE.
- sample_data and fir_coefficient hold their last driven value outside the drive states.
- Timeout:
  - A timer resets on every state entry and counts while in COEF_DRIVE, COEF_WAIT, SAMP_DRIVE or SAMP_WAIT.
  - When the timer reaches TIMEOUT: timeout_err←1, strobes←0, go to IDLE.
  - An aborted sample is not popped if the abort happens in SAMP_DRIVE.
  - An aborted reload sequence is dropped, not retried.
- Minimum latency per sample, filter responding instantly: IDLE→DRIVE 1 cycle, DRIVE→WAIT 1 cycle, WAIT→result 1 cycle.
- rst mid-operation: strobes drop asynchronously, FIFO contents are discarded, and no result_valid is produced.

Test Plan:
- Coefficient load: write slots 0..3 = 0x0001, 0x0002, 0x0003, 0x0004; pulse reload; model raises modwait 2 cycles after load_coeff and drops it 3 cycles later -> fir_coefficient sequence 1,2,3,4, four load_coeff pulses, single coeff_done after the 4th modwait fall.
- Single sample: push 0x1234; model returns fir_out=0x0ABC, err=0 -> data_ready high until modwait rises, sample_data=0x1234, result_valid one cycle with result_data=0x0ABC.
- FIFO full: push 5 samples back-to-back with modwait held 1 -> sample_ready=0 after the 4th push, 5th push ignored; samples then issued in order.
- Priority: FIFO holds 2 samples and reload pulses during SAMP_WAIT -> the current result completes, then all 4 coefficients load before the next sample.
- Timeout: modwait never rises after data_ready -> after 16 cycles timeout_err=1 and data_ready=0; the sample remains in the FIFO and is reissued once modwait behaves.
- Async reset: assert rst during COEF_WAIT -> load_coeff, data_ready and result_valid are 0 immediately, sample_ready=1 after release, and no coeff_done is produced.
